// File: rtl/ahb_resp_mux_n.sv
// ahb_resp_mux_n: AHB-Lite slave-to-master response multiplexer with a built-in
// default slave. The decoder's select is registered in the address phase and
// steers hrdata/hready/hresp in the data phase. Active transfers to unmapped
// space get the two-cycle ERROR response from a small default-slave FSM.
// Optional build macro AHB_MUX_ONEHOT_CHK_EN adds a sticky sel_err flag. An
// active transfer with a multi-hot select sets it and is treated as unmapped.
module ahb_resp_mux_n #(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             hclk,
   input  logic                             hresetn,
   input  logic [NUM_SLAVES-1:0]            hsel,
   input  logic [1:0]                       htrans,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
   input  logic [NUM_SLAVES-1:0]            hreadyout_s,
   input  logic [NUM_SLAVES-1:0]            hresp_s,
   output logic [DATA_WIDTH-1:0]            hrdata,
   output logic                             hready,
   output logic                             hresp,
`ifdef AHB_MUX_ONEHOT_CHK_EN
   output logic                             sel_err,
`endif
   output logic [NUM_SLAVES-1:0]            dp_sel
);

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   ds_state_t             state;
   ds_state_t             state_nxt;
   logic                  capture;
   logic                  active;
   logic                  unmapped;
   logic [NUM_SLAVES-1:0] sel_load;
   logic                  unused_htrans0;

   // Only NONSEQ/SEQ matter; BUSY and IDLE are both "no transfer" here.
   assign active         = htrans[1];
   assign unused_htrans0 = htrans[0];

   // An address phase is accepted on every edge where the bus is ready.
   assign capture = hready;

`ifdef AHB_MUX_ONEHOT_CHK_EN
   logic multi_hot;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_hot = active && ((hsel & (hsel - NUM_SLAVES'(1))) != '0);
   assign unmapped  = active && ((hsel == '0) || multi_hot);
   assign sel_load  = multi_hot ? '0 : hsel;
`else
   assign unmapped  = active && (hsel == '0);
   assign sel_load  = hsel;
`endif

   // State register: FSM, data-phase select and (optionally) the sticky error flag.
   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of block ordering.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state   <= DS_IDLE;
         dp_sel  <= '0;
`ifdef AHB_MUX_ONEHOT_CHK_EN
         sel_err <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (capture) begin
            dp_sel <= sel_load;
         end
`ifdef AHB_MUX_ONEHOT_CHK_EN
         if (capture && multi_hot) begin
            sel_err <= 1'b1;
         end
`endif
      end
   end

   // Default-slave next state: ERR1 -> ERR2 always, and ERR2 may chain straight
   // into ERR1 when the next captured transfer is unmapped as well.
   // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         DS_IDLE: if (capture && unmapped) state_nxt = DS_ERR1;
         DS_ERR1: state_nxt = DS_ERR2;
         DS_ERR2: state_nxt = (capture && unmapped) ? DS_ERR1 : DS_IDLE;
         default: state_nxt = DS_IDLE;
      endcase
   end

   // Response routing from registered state and slave inputs only; the
   // descending loop lets the lowest-index set bit have the final say.
   always_comb begin
      hrdata = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      if (state == DS_ERR1) begin
         hready = 1'b0;
         hresp  = 1'b1;
      end else if (state == DS_ERR2) begin
         hresp  = 1'b1;
      end else begin
         for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (dp_sel[i]) begin
               hrdata = hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
               hready = hreadyout_s[i];
               hresp  = hresp_s[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// tb_ahb_resp_mux_n: table-driven bench for ahb_resp_mux_n (4 slaves, 32 bits).
// Each row gives the inputs driven for one cycle and the outputs expected in
// that same cycle, which reflect the state captured on the previous edge.
module tb_ahb_resp_mux_n;

   localparam int NS = 4;
   localparam int DW = 32;

   logic               hclk = 1'b0;
   logic               hresetn;
   logic [NS-1:0]      hsel;
   logic [1:0]         htrans;
   logic [NS*DW-1:0]   hrdata_s;
   logic [NS-1:0]      hreadyout_s;
   logic [NS-1:0]      hresp_s;
   logic [DW-1:0]      hrdata;
   logic               hready;
   logic               hresp;
   logic [NS-1:0]      dp_sel;
`ifdef AHB_MUX_ONEHOT_CHK_EN
   logic               sel_err;
`endif

   ahb_resp_mux_n #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) dut (
      .hclk        (hclk),
      .hresetn     (hresetn),
      .hsel        (hsel),
      .htrans      (htrans),
      .hrdata_s    (hrdata_s),
      .hreadyout_s (hreadyout_s),
      .hresp_s     (hresp_s),
      .hrdata      (hrdata),
      .hready      (hready),
      .hresp       (hresp),
`ifdef AHB_MUX_ONEHOT_CHK_EN
      .sel_err     (sel_err),
`endif
      .dp_sel      (dp_sel)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic          rst_n;
      logic          rnd;
      logic [NS-1:0] sel;
      logic [1:0]    trans;
      logic [NS-1:0] rdy_s;
      logic [NS-1:0] resp_s;
      logic          e_rdy;
      logic          e_resp;
      logic [NS-1:0] e_dp;
      int            e_src;
      logic          e_serr;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          rdy;
      logic          resp;
      logic [NS-1:0] dp;
      logic          serr;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst_n, input logic rnd, input logic [NS-1:0] sel,
                      input logic [1:0] trans, input logic [NS-1:0] rdy_s,
                      input logic [NS-1:0] resp_s, input logic e_rdy, input logic e_resp,
                      input logic [NS-1:0] e_dp, input int e_src, input logic e_serr);
      vec_t v;
      v.rst_n = rst_n; v.rnd = rnd; v.sel = sel; v.trans = trans;
      v.rdy_s = rdy_s; v.resp_s = resp_s; v.e_rdy = e_rdy; v.e_resp = e_resp;
      v.e_dp = e_dp; v.e_src = e_src; v.e_serr = e_serr;
      vecs.push_back(v);
   endtask

   function automatic logic [DW-1:0] base_data(input int i);
      return 32'hCAFE_0000 | DW'(i);
   endfunction

   task automatic set_base_data();
      for (int i = 0; i < NS; i++) hrdata_s[i*DW +: DW] = base_data(i);
   endtask

   initial begin
      exp_t e;
      vec_t v;
      bit   found;
      int   waited;

      hresetn     = 1'b0;
      hsel        = '0;
      htrans      = 2'b00;
      hreadyout_s = '1;
      hresp_s     = '0;
      set_base_data();

      //  rst  rnd  hsel     trans  rdy_s    resp_s   e_rdy e_resp e_dp     src e_serr
      // Reset held three cycles with random slave inputs.
      add(0, 1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
      add(0, 1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
      add(0, 1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
      // Routing to slave 2, then slave 1 with two wait states while hsel moves to slave 3.
      add(1, 0, 4'b0100, 2'b10, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
      add(1, 0, 4'b0010, 2'b10, 4'b1111, 4'b0000, 1, 0, 4'b0100,  2, 0);
      add(1, 0, 4'b1000, 2'b10, 4'b1101, 4'b0000, 0, 0, 4'b0010,  1, 0);
      add(1, 0, 4'b1000, 2'b10, 4'b1101, 4'b0000, 0, 0, 4'b0010,  1, 0);
      add(1, 0, 4'b1000, 2'b10, 4'b1111, 4'b0000, 1, 0, 4'b0010,  1, 0);
      // Slave 3 ERROR passes through; unmapped NONSEQ issued in the same cycle.
      add(1, 0, 4'b0000, 2'b10, 4'b1111, 4'b1000, 1, 1, 4'b1000,  3, 0);
      add(1, 0, 4'b0001, 2'b10, 4'b1111, 4'b0000, 0, 1, 4'b0000, -1, 0);
      add(1, 0, 4'b0001, 2'b10, 4'b1111, 4'b0000, 1, 1, 4'b0000, -1, 0);
      add(1, 0, 4'b0000, 2'b10, 4'b1111, 4'b0000, 1, 0, 4'b0001,  0, 0);
      // Cancel during ERR1, SEQ unmapped during ERR2: ERR1, ERR2, ERR1, ERR2.
      add(1, 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 1, 4'b0000, -1, 0);
      add(1, 0, 4'b0000, 2'b11, 4'b1111, 4'b0000, 1, 1, 4'b0000, -1, 0);
      add(1, 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 1, 4'b0000, -1, 0);
      add(1, 0, 4'b0000, 2'b01, 4'b1111, 4'b0000, 1, 1, 4'b0000, -1, 0);
      // BUSY to unmapped gives zero-wait OKAY; then reset lands during ERR1.
      add(1, 0, 4'b0000, 2'b10, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
      add(0, 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 1, 4'b0000, -1, 0);
      // Multi-hot select.
      add(1, 0, 4'b0110, 2'b10, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
`ifdef AHB_MUX_ONEHOT_CHK_EN
      add(1, 0, 4'b0000, 2'b00, 4'b1011, 4'b0100, 0, 1, 4'b0000, -1, 1);
      add(1, 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 1, 4'b0000, -1, 1);
      add(1, 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 1);
`else
      add(1, 0, 4'b0000, 2'b00, 4'b1011, 4'b0100, 1, 0, 4'b0110,  1, 0);
      add(1, 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
      add(1, 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1, 0);
`endif

      foreach (vecs[k]) begin
         v = vecs[k];
         @(posedge hclk);
         #1;
         hresetn     = v.rst_n;
         hsel        = v.sel;
         htrans      = v.trans;
         hreadyout_s = v.rnd ? NS'($urandom) : v.rdy_s;
         hresp_s     = v.rnd ? NS'($urandom) : v.resp_s;
         if (v.rnd) begin
            for (int i = 0; i < NS; i++) hrdata_s[i*DW +: DW] = $urandom;
         end else begin
            set_base_data();
         end
         e.data = (v.e_src < 0) ? '0 : base_data(v.e_src);
         e.rdy  = v.e_rdy;
         e.resp = v.e_resp;
         e.dp   = v.e_dp;
         e.serr = v.e_serr;
         exp_q.push_back(e);
         #1;
         e = exp_q.pop_front();
         check($sformatf("row%0d hrdata", k), 64'(hrdata), 64'(e.data));
         check($sformatf("row%0d hready", k), 64'(hready), 64'(e.rdy));
         check($sformatf("row%0d hresp", k),  64'(hresp),  64'(e.resp));
         check($sformatf("row%0d dp_sel", k), 64'(dp_sel), 64'(e.dp));
`ifdef AHB_MUX_ONEHOT_CHK_EN
         check($sformatf("row%0d sel_err", k), 64'(sel_err), 64'(e.serr));
`endif
      end

      // Hand sequence: read data follows the slave within the cycle (no added latency).
      @(posedge hclk);
      #1;
      hsel = 4'b0001; htrans = 2'b10; hreadyout_s = 4'b1111;
      @(posedge hclk);
      #1;
      hsel = '0; htrans = 2'b00; hreadyout_s = 4'b1110;
      hrdata_s[0 +: DW] = 32'h1234_5678;
      #1;
      check("live hrdata a", 64'(hrdata), 64'h1234_5678);
      check("live hready",   64'(hready), 64'h0);
      check("live dp_sel",   64'(dp_sel), 64'h1);
      hrdata_s[0 +: DW] = 32'h8765_4321;
      #1;
      check("live hrdata b", 64'(hrdata), 64'h8765_4321);

      // Hand sequence: bounded wait for slave 0 to release its wait state.
      found  = 1'b0;
      waited = 0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(posedge hclk);
         #1;
         if (n == 2) hreadyout_s = 4'b1111;
         #1;
         if (hready) begin
            found  = 1'b1;
            waited = n;
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL hready wait: timed out after 10 cycles, expected release at cycle 2");
      end else begin
         check("wait cycles", 64'(waited), 64'd2);
         check("wait dp_sel", 64'(dp_sel), 64'h1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_resp_mux_n.md
Name: ahb_resp_mux_n

Overview:
- Parametrised AHB-Lite slave-to-master response multiplexer with N slave ports, plus a built-in default slave.
- Captures the decoder's one-hot slave select in the address phase and holds it for the data phase. Uses the held select to route hrdata/hreadyout/hresp from the addressed slave back to the master.
- Active transfers to unmapped addresses (no select bit set) receive the AHB two-cycle ERROR response from an internal FSM.
- Sits between the address decoder / slaves and the master in the interconnect.

Parameters:
- NUM_SLAVES, 4, number of slave ports; legal range 2..16.
- DATA_WIDTH, 32, read data width; legal values 32 or 64.

Ports:
- hclk  input  1  bus clock; all state updates on the rising edge.
- hresetn  input  1  reset; synchronous, active-low.
- hsel  input  NUM_SLAVES  one-hot address-phase select from the decoder; bit i selects slave i.
- htrans  input  2  master transfer type; 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hrdata_s  input  NUM_SLAVES*DATA_WIDTH  slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH].
- hreadyout_s  input  NUM_SLAVES  per-slave ready.
- hresp_s  input  NUM_SLAVES  per-slave response; 0 OKAY, 1 ERROR.
- hrdata  output  DATA_WIDTH  read data to the master.
- hready  output  1  bus ready; goes to the master and is fed back to all slaves.
- hresp  output  1  response to the master.
- dp_sel  output  NUM_SLAVES  registered data-phase select (debug/monitor).

Behaviour:
- Reset (hresetn=0 at a rising edge):
  - dp_sel=0; FSM=DS_IDLE.
  - Outputs are combinational from this state, so during and after reset: hready=1, hresp=0, hrdata=0.
- Address-phase capture happens at each rising edge where hready=1:
  - dp_sel <= hsel.
  - unmapped = (hsel==0) and htrans[1]==1.
  - If unmapped: FSM <= DS_ERR1.
- When hready=0: dp_sel and the captured select hold; hsel/htrans are ignored.
- Output routing, purely combinational from dp_sel and FSM; zero added latency; priority in this order:
  - FSM=DS_ERR1: hready=0, hresp=1, hrdata=0.
  - FSM=DS_ERR2: hready=1, hresp=1, hrdata=0.
  - dp_sel bit i set: hrdata=hrdata_s[i], hready=hreadyout_s[i], hresp=hresp_s[i].
  - dp_sel=0, FSM=DS_IDLE: hready=1, hresp=0, hrdata=0. This covers IDLE/BUSY to unmapped space and the no-transfer case.
- Default-slave FSM:
  - DS_IDLE -> DS_ERR1 on an unmapped capture.
  - DS_ERR1 -> DS_ERR2 unconditionally (1 cycle).
  - DS_ERR2 -> DS_ERR1 if the capture at this edge (hready=1) is again unmapped; otherwise -> DS_IDLE.
  - The capture at the DS_ERR2 edge loads dp_sel normally, so back-to-back transfers need no bubble.
- Master cancels during ERR1 (htrans driven to IDLE): no effect on the FSM; ERR2 is still issued.
- Slave ERROR responses: passed through unchanged. The mux does not enforce the two-cycle shape on slaves.
- Multi-hot hsel: lowest-index set bit wins in routing; dp_sel still stores the raw vector.
- Reset mid-transfer (any FSM state, any dp_sel): the next edge with hresetn=0 forces reset state; the in-flight response is dropped.
- No combinational path from hsel/htrans to any output. Outputs depend only on registered state and slave inputs.

Optional Feature:
- Macro AHB_MUX_ONEHOT_CHK_EN.
- With the macro:
  - Adds output sel_err (1 bit), a sticky register; cleared only by reset.
  - sel_err is set when a capture edge sees an active htrans with more than one hsel bit set.
  - That transfer is treated as unmapped (dp_sel <= 0, FSM -> DS_ERR1).
- Without the macro: no sel_err port; multi-hot follows the lowest-index rule above.

Test Plan (NUM_SLAVES=4, DATA_WIDTH=32):
- Reset: hold hresetn=0 for 3 cycles with random slave inputs -> hready=1, hresp=0, hrdata=0, dp_sel=4'b0000 after the first reset edge.
- Routing: NONSEQ with hsel=4'b0100, hrdata_s slice2=32'hCAFE_0002, hreadyout_s=4'b1111 -> next cycle dp_sel=4'b0100, hrdata=32'hCAFE_0002, hready=1, hresp=0.
- Wait states: slave1 selected, hreadyout_s[1]=0 for 2 cycles while hsel changes to 4'b1000 -> hready=0 for 2 cycles and dp_sel stays 4'b0010; the capture of 4'b1000 occurs on the cycle hreadyout_s[1] returns to 1.
- Unmapped: NONSEQ with hsel=0 -> cycle+1 hready=0, hresp=1; cycle+2 hready=1, hresp=1; cycle+3 routing returns to the newly captured slave with hresp=0.
- Back-to-back unmapped: NONSEQ hsel=0, then SEQ hsel=0 presented during ERR2 -> response sequence ERR1, ERR2, ERR1, ERR2 with no OKAY cycle between.
- Idle/BUSY to unmapped and mid-error reset: htrans=01 with hsel=0 -> zero-wait OKAY; separately, hresetn=0 during DS_ERR1 -> next cycle hready=1, hresp=0 (with AHB_MUX_ONEHOT_CHK_EN: hsel=4'b0011 with NONSEQ -> sel_err=1 and ERROR response).
